// File: rtl/base_ram_arbiter_pkg.sv
// Shared constants and types for the base-RAM port arbiter.
// The arbiter has one optional feature, enabled by defining ARB_PERF_CNT_EN.
package base_ram_arbiter_pkg;

  localparam int DATA_BUS_W = 32;

  // Arbiter FSM encodings, kept as plain constants for legacy tools
  localparam logic [0:0] ARB_S_IF    = 1'b0;
  localparam logic [0:0] ARB_S_IFPRI = 1'b1;

  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [3:0] SEL_ALL = 4'b1111;

  // Which requester owns the wrapper port in the current cycle
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_MEM  = 2'd2
  } grant_e;

endpackage

// File: rtl/base_ram_arbiter_arb_inst_buf.sv
// One-entry instruction buffer: holds the word fetched while the pipeline is
// stalled so that IF does not need the RAM port again for the same address.
// A granted MEM write to the buffered word address drops the entry.
module arb_inst_buf
  import base_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_ce_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  input  logic                  pipe_stall_i,
  input  logic                  if_gnt_i,
  input  logic [DATA_BUS_W-1:0] inst_i,
  input  logic                  wr_inval_i,
  input  logic [ADDR_W-3:0]     wr_word_i,
  output logic                  hit_o,
  output logic [DATA_BUS_W-1:0] buf_inst_o
);

  logic                  valid_q, valid_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_BUS_W-1:0] inst_q, inst_d;
  logic                  capture;

  assign hit_o      = valid_q && if_ce_i && (if_addr_i == addr_q);
  assign buf_inst_o = inst_q;
  assign capture    = (if_gnt_i || hit_o) && pipe_stall_i;

  // Capture on a stalled fetch, release once the pipeline accepts it;
  // a coherent write clear overrides a same-cycle capture
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    if (capture) begin
      valid_d = 1'b1;
      addr_d  = if_addr_i;
      inst_d  = inst_i;
    end else if (!pipe_stall_i && if_ce_i) begin
      valid_d = 1'b0;
    end
    if (wr_inval_i && (wr_word_i == addr_q[ADDR_W-1:2])) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      inst_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
    end
  end

endmodule

// File: rtl/base_ram_arbiter.sv
// Arbiter for the single base-RAM/UART wrapper port. MEM normally wins a
// conflict; after STARVE_LIMIT consecutive lost conflicts IF gets one cycle
// of priority. Grant and data muxing are combinational because the wrapper
// answers in the same cycle.
// Optional: define ARB_PERF_CNT_EN to count IF stall cycles on perf_if_stall_o.
module base_ram_arbiter
  import base_ram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_stall_i,
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [31:0]       if_inst_o,
  output logic              if_stall_req_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic              mem_stall_req_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_sel_o,
  output logic [31:0]       ram_data_o,
  input  logic [31:0]       ram_data_i,
  output logic [31:0]       perf_if_stall_o
);

  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  logic [0:0] state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  grant_e     gnt;
  logic       buf_hit;
  logic       if_need;
  logic [31:0] buf_inst;

  assign if_need = if_ce_i && !buf_hit;

  // Grant decision, stall requests and next FSM/counter state
  always_comb begin
    state_d         = state_q;
    starve_cnt_d    = starve_cnt_q;
    gnt             = GNT_NONE;
    if_stall_req_o  = 1'b0;
    mem_stall_req_o = 1'b0;
    if (state_q == ARB_S_IFPRI) begin
      state_d      = ARB_S_IF;
      starve_cnt_d = '0;
      if (if_need) begin
        gnt             = GNT_IF;
        mem_stall_req_o = mem_ce_i;
      end else if (mem_ce_i) begin
        gnt = GNT_MEM;
      end
    end else if (mem_ce_i) begin
      gnt = GNT_MEM;
      if (if_need) begin
        if_stall_req_o = 1'b1;
        starve_cnt_d   = starve_cnt_q + 4'd1;
        if (starve_cnt_d == LIMIT_C) begin
          state_d = ARB_S_IFPRI;
        end
      end else begin
        starve_cnt_d = '0;
      end
    end else begin
      starve_cnt_d = '0;
      if (if_need) begin
        gnt = GNT_IF;
      end
    end
    // Reset silences every output and grant
    if (rst) begin
      gnt             = GNT_NONE;
      if_stall_req_o  = 1'b0;
      mem_stall_req_o = 1'b0;
    end
  end

  // Port and return-data muxing driven by the grant
  always_comb begin
    ram_ce_o   = CHIP_DISABLE;
    ram_we_o   = WRITE_DISABLE;
    ram_addr_o = '0;
    ram_sel_o  = '0;
    ram_data_o = '0;
    mem_data_o = '0;
    if_inst_o  = buf_hit ? buf_inst : '0;
    case (gnt)
      GNT_IF: begin
        ram_ce_o   = CHIP_ENABLE;
        ram_sel_o  = SEL_ALL;
        ram_addr_o = if_addr_i;
        if_inst_o  = ram_data_i;
      end
      GNT_MEM: begin
        ram_ce_o   = CHIP_ENABLE;
        ram_we_o   = mem_we_i;
        ram_addr_o = mem_addr_i;
        ram_sel_o  = mem_sel_i;
        ram_data_o = mem_data_i;
        mem_data_o = ram_data_i;
      end
      default: ;
    endcase
    if (rst) begin
      if_inst_o = '0;
    end
  end

  // FSM state and starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_S_IF;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  arb_inst_buf #(
    .ADDR_W (ADDR_W)
  ) u_inst_buf (
    .clk          (clk),
    .rst          (rst),
    .if_ce_i      (if_ce_i),
    .if_addr_i    (if_addr_i),
    .pipe_stall_i (pipe_stall_i),
    .if_gnt_i     (gnt == GNT_IF),
    .inst_i       (if_inst_o),
    .wr_inval_i   ((gnt == GNT_MEM) && mem_we_i),
    .wr_word_i    (mem_addr_i[ADDR_W-1:2]),
    .hit_o        (buf_hit),
    .buf_inst_o   (buf_inst)
  );

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_q;

  // IF stall-cycle counter, wraps naturally at 32 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (if_stall_req_o) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_if_stall_o = perf_q;
`else
  assign perf_if_stall_o = '0;
`endif

endmodule

// File: tb/tb_base_ram_arbiter.sv
// Bench for base_ram_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_base_ram_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst, pipe_stall, if_ce, mem_ce, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] if_inst, mem_rdata, ram_addr, ram_wdata, ram_rdata, perf;
  logic        if_stall, mem_stall, ram_ce, ram_we;
  logic [3:0]  ram_sel;

  logic [31:0] ram_mem [0:7];

  int total = 0;
  int bad   = 0;

  // Model state
  int          m_streak;
  bit          m_pri;
  bit          m_bv;
  logic [31:0] m_ba, m_bi, m_perf;

  // Pending wrapper write, applied at the following clock edge
  bit          wr_pend;
  logic [2:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_sel;

  always #5 clk = ~clk;

  always_comb ram_rdata = ram_ce ? ram_mem[ram_addr[4:2]] : 32'h0;

  base_ram_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .pipe_stall_i(pipe_stall),
    .if_ce_i(if_ce), .if_addr_i(if_addr), .if_inst_o(if_inst),
    .if_stall_req_o(if_stall),
    .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_sel_i(mem_sel), .mem_data_i(mem_wdata), .mem_data_o(mem_rdata),
    .mem_stall_req_o(mem_stall),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_sel_o(ram_sel), .ram_data_o(ram_wdata), .ram_data_i(ram_rdata),
    .perf_if_stall_o(perf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model, then advance the model
  task automatic model_cycle();
    bit hit, need_if, mg, ig, cap, inval;
    logic [31:0] e_if_inst, e_mem_data, e_addr, e_wdata, presented;
    logic [3:0]  e_sel;
    bit e_ce, e_we, e_ifs, e_ms;
    hit = m_bv && if_ce && (if_addr == m_ba);
    need_if = if_ce && !hit;
    mg = 0; ig = 0; e_ifs = 0; e_ms = 0;
    if (!rst) begin
      if (m_pri) begin
        ig = need_if;
        mg = !need_if && mem_ce;
        e_ms = need_if && mem_ce;
      end else if (mem_ce) begin
        mg = 1;
        e_ifs = need_if;
      end else begin
        ig = need_if;
      end
    end
    e_ce = ig || mg;
    e_we = mg && mem_we;
    e_addr = ig ? if_addr : (mg ? mem_addr : 32'h0);
    e_sel = ig ? 4'hF : (mg ? mem_sel : 4'h0);
    e_wdata = mg ? mem_wdata : 32'h0;
    e_mem_data = mg ? ram_mem[mem_addr[4:2]] : 32'h0;
    if (rst) e_if_inst = 32'h0;
    else if (ig) e_if_inst = ram_mem[if_addr[4:2]];
    else e_if_inst = hit ? m_bi : 32'h0;

    chk("ram_ce", 32'(ram_ce), 32'(e_ce));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_sel", 32'(ram_sel), 32'(e_sel));
    chk("ram_data", ram_wdata, e_wdata);
    chk("mem_data", mem_rdata, e_mem_data);
    chk("if_inst", if_inst, e_if_inst);
    chk("if_stall", 32'(if_stall), 32'(e_ifs));
    chk("mem_stall", 32'(mem_stall), 32'(e_ms));
`ifdef ARB_PERF_CNT_EN
    chk("perf", perf, m_perf);
`else
    chk("perf", perf, 32'h0);
`endif

    if (rst) begin
      m_streak = 0; m_pri = 0; m_bv = 0; m_ba = 0; m_bi = 0; m_perf = 0;
    end else begin
      if (e_ifs) m_perf = m_perf + 32'd1;
      if (m_pri) begin
        m_pri = 0; m_streak = 0;
      end else if (mem_ce && need_if) begin
        m_streak++;
        m_pri = (m_streak == LIMIT);
      end else begin
        m_streak = 0;
      end
      presented = e_if_inst;
      cap = (ig || hit) && pipe_stall;
      inval = mg && mem_we && (mem_addr[31:2] == m_ba[31:2]);
      if (cap) begin
        m_bv = 1; m_ba = if_addr; m_bi = presented;
      end else if (!pipe_stall && if_ce) begin
        m_bv = 0;
      end
      if (inval) m_bv = 0;
    end
    wr_pend = ram_ce && ram_we;
    wr_idx = ram_addr[4:2];
    wr_data = ram_wdata;
    wr_sel = ram_sel;
  endtask

  task automatic step(input logic r, input logic ps, input logic ice, input logic [31:0] ia,
                      input logic mce, input logic mwe, input logic [31:0] ma,
                      input logic [3:0] ms, input logic [31:0] md);
    @(posedge clk);
    if (wr_pend) begin
      for (int b = 0; b < 4; b++)
        if (wr_sel[b]) ram_mem[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
      wr_pend = 0;
    end
    #1;
    rst = r; pipe_stall = ps; if_ce = ice; if_addr = ia;
    mem_ce = mce; mem_we = mwe; mem_addr = ma; mem_sel = ms; mem_wdata = md;
    #3;
    model_cycle();
  endtask

  initial begin
    rst = 1; pipe_stall = 0; if_ce = 0; mem_ce = 0; mem_we = 0;
    if_addr = 0; mem_addr = 0; mem_sel = 0; mem_wdata = 0;
    wr_pend = 0; wr_idx = 0; wr_data = 0; wr_sel = 0;
    m_streak = 0; m_pri = 0; m_bv = 0; m_ba = 0; m_bi = 0; m_perf = 0;
    for (int i = 0; i < 8; i++) ram_mem[i] = 32'hA000_0000 | i;
    ram_mem[0] = 32'h2401_0001;

    // Reset with both requesters active: everything silent
    step(1, 0, 1, 32'h8000_0000, 1, 0, 32'h8040_0000, 4'hF, 0);
    step(1, 0, 1, 32'h8000_0000, 1, 0, 32'h8040_0000, 4'hF, 0);
    chk("rst_ram_ce", 32'(ram_ce), 0);
    chk("rst_if_stall", 32'(if_stall), 0);
    chk("rst_if_inst", if_inst, 0);

    // Plain fetch
    step(0, 0, 1, 32'h8000_0000, 0, 0, 0, 0, 0);
    chk("t1_inst", if_inst, 32'h2401_0001);
    chk("t1_we", 32'(ram_we), 0);
    chk("t1_stall", 32'({if_stall, mem_stall}), 0);

    // Conflict, then IF once MEM goes idle
    step(0, 0, 1, 32'h8000_0004, 1, 0, 32'h8040_0000, 4'hF, 0);
    chk("t2_if_stall", 32'(if_stall), 1);
    chk("t2_addr", ram_addr, 32'h8040_0000);
    chk("t2_mem_data", mem_rdata, 32'h2401_0001);
    step(0, 0, 1, 32'h8000_0004, 0, 0, 0, 0, 0);
    chk("t2b_addr", ram_addr, 32'h8000_0004);
    chk("t2b_inst", if_inst, 32'hA000_0001);

    // Starvation guard
    for (int c = 1; c <= 5; c++) begin
      step(0, 0, 1, 32'h8000_000C, 1, 0, 32'h8040_0004, 4'hF, 0);
      if (c < 5) chk("t3_if_stall", 32'(if_stall), 1);
    end
    chk("t3_mem_stall", 32'(mem_stall), 1);
    chk("t3_if_addr", ram_addr, 32'h8000_000C);
    step(0, 0, 1, 32'h8000_0010, 1, 0, 32'h8040_0004, 4'hF, 0);
    chk("t3_mem_again", ram_addr, 32'h8040_0004);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Buffered fetch served while MEM stores
    step(0, 1, 1, 32'h8000_0008, 0, 0, 0, 0, 0);
    chk("t4_fetch", if_inst, 32'hA000_0002);
    for (int c = 0; c < 2; c++) begin
      step(0, 1, 1, 32'h8000_0008, 1, 1, 32'h8040_0010, 4'hF, 32'h5555_5555);
      chk("t4_no_stall", 32'(if_stall), 0);
      chk("t4_we", 32'(ram_we), 1);
      chk("t4_inst", if_inst, 32'hA000_0002);
    end

    // Write to the buffered word invalidates the entry
    step(0, 1, 1, 32'h8000_0008, 1, 1, 32'h8000_0008, 4'hF, 32'h1111_1111);
    step(0, 0, 1, 32'h8000_0008, 0, 0, 0, 0, 0);
    chk("t5_ram_ce", 32'(ram_ce), 1);
    chk("t5_inst", if_inst, 32'h1111_1111);

    // Reset mid-conflict, then count stalls
    step(0, 0, 1, 32'h8000_0014, 1, 0, 32'h8040_0000, 4'hF, 0);
    step(1, 0, 1, 32'h8000_0014, 1, 0, 32'h8040_0000, 4'hF, 0);
    chk("t6_ce", 32'(ram_ce), 0);
    chk("t6_stall", 32'({if_stall, mem_stall}), 0);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 1, 32'h8000_0014, 1, 0, 32'h8040_0000, 4'hF, 0);
      chk("t6_mem_first", ram_addr, 32'h8040_0000);
`ifdef ARB_PERF_CNT_EN
      if (c == 0) chk("t6_perf0", perf, 0);
`endif
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef ARB_PERF_CNT_EN
    chk("t6_perf3", perf, 3);
`else
    chk("t6_perf_off", perf, 0);
`endif

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic r, ps, ice, mce, mwe;
      logic [31:0] ia, ma;
      r   = ($urandom_range(0, 199) == 0);
      ps  = ($urandom_range(0, 9) < 4);
      ice = ($urandom_range(0, 9) < 8);
      mce = ($urandom_range(0, 9) < 5);
      mwe = $urandom_range(0, 1);
      ia  = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 2);
      ma  = ($urandom_range(0, 1) ? 32'h8000_0000 : 32'h8040_0000)
            | (32'($urandom_range(0, 7)) << 2);
      step(r, ps, ice, ia, mce, mwe, ma, 4'($urandom_range(0, 15)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/base_ram_arbiter.md
Name: base_ram_arbiter

Overview:
- Sits directly upstream of the base-RAM/UART wrapper and owns its single request port.
- Arbitrates between instruction fetch (IF) and data access (MEM) on that port. MEM has priority, with a starvation guard for IF.
- Holds a one-entry instruction buffer so a stalled IF does not re-occupy the port.
- Generates stall requests to the pipeline controller.

Parameters:
- STARVE_LIMIT, 4: consecutive MEM grants allowed while IF waits; on the next conflict cycle IF wins and MEM stalls. Legal range 1..15.
- ADDR_W, 32: address width of both requesters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pipe_stall_i  in  1  IF/ID held by the controller this cycle
- if_ce_i  in  1  fetch request
- if_addr_i  in  ADDR_W  fetch address (word aligned)
- if_inst_o  out  32  fetched instruction
- if_stall_req_o  out  1  IF must hold this cycle
- mem_ce_i  in  1  data request
- mem_we_i  in  1  1 = write
- mem_addr_i  in  ADDR_W  data address (UART addresses pass through untouched)
- mem_sel_i  in  4  byte enables
- mem_data_i  in  32  write data
- mem_data_o  out  32  read data
- mem_stall_req_o  out  1  MEM must hold this cycle
- ram_ce_o, ram_we_o  out  1 each  to wrapper ce_i / we_i
- ram_addr_o  out  ADDR_W  to wrapper addr_i
- ram_sel_o  out  4  to wrapper sel_i
- ram_data_o  out  32  to wrapper data_i
- ram_data_i  in  32  from wrapper data_o (combinational, same-cycle)
- perf_if_stall_o  out  32  IF stall-cycle count (see Optional Feature)

Behaviour:
- The wrapper completes every access in the same cycle, so grant and mux are combinational. State, counter and buffer are registered.
- Reset, all synchronous on rst=1 at the clock edge:
  - state=S_IF, starve_cnt=0, buf_valid=0, buf_addr=0, buf_inst=0.
  - While rst is high, all outputs are 0 and stall requests are 0.
  - A reset mid-access drops the buffer; no RAM side effect is retained.
- buf_hit = buf_valid && if_ce_i && (if_addr_i == buf_addr). On a hit, IF is served from buf_inst and needs no port.
- IF needs the port when if_ce_i && !buf_hit.
- States:
  - S_IF, normal. MEM needs the port:
    - If IF also needs it: MEM granted, if_stall_req_o=1, starve_cnt++. If starve_cnt reaches STARVE_LIMIT, go to S_IFPRI.
    - If IF does not need it: MEM granted, starve_cnt=0.
  - S_IF, MEM idle: IF granted if needed, starve_cnt=0.
  - S_IFPRI, one cycle only:
    - If IF needs the port: IF granted and mem_stall_req_o=1 if mem_ce_i.
    - Always return to S_IF with starve_cnt=0.
    - If IF no longer needs the port (hit or no request), MEM is granted normally.
- Grant MEM: ram_* = mem_*, mem_data_o = ram_data_i, if_inst_o = buf_hit ? buf_inst : 0.
- Grant IF: ram_ce_o=1, ram_we_o=0, ram_sel_o=4'b1111, ram_addr_o=if_addr_i, ram_data_o=0, if_inst_o=ram_data_i, mem_data_o=0.
- No grant: ram_ce_o=0, all other ram_* outputs 0.
- Buffer capture happens when IF is granted, or served by a hit, and pipe_stall_i=1:
  - buf_valid<=1, buf_addr<=if_addr_i, buf_inst<=instruction presented.
- buf_valid clears on the first cycle with pipe_stall_i=0 and if_ce_i=1, after the instruction is presented that cycle.
- Any MEM write whose word address equals buf_addr clears buf_valid, so self-modifying code stays coherent. If the same cycle also captures, the clear wins.
- if_ce_i=0: no IF activity, if_stall_req_o=0, buffer kept.
- mem_stall_req_o and if_stall_req_o are never both 1.

Optional Feature:
- ARB_PERF_CNT_EN defined:
  - 32-bit counter increments each cycle if_stall_req_o=1, and wraps from 0xFFFFFFFF to 0.
  - The counter is cleared by rst and driven on perf_if_stall_o.
- ARB_PERF_CNT_EN undefined: perf_if_stall_o tied to 0 and no counter flop is synthesised.

Decomposition:
- defines.vh: `ChipEnable/`ChipDisable, `WriteEnable, `DataBus, `DataAddrBus, `InstBus, state encodings `ARB_S_IF/`ARB_S_IFPRI.
- Sub-module arb_inst_buf holds the buffer registers, hit compare, capture and invalidate logic. The top holds the FSM and muxes.

Test Plan:
1. Fetch only, pipe_stall_i=0, addr 0x80000000, RAM returns 0x24010001 -> if_inst_o=0x24010001 same cycle, ram_we_o=0, no stalls.
2. Conflict: IF 0x80000004 + MEM read 0x80400000 -> MEM granted, if_stall_req_o=1, mem_data_o=ram_data_i; next cycle with MEM idle IF granted.
3. Starvation: MEM requests on 5 consecutive cycles with IF waiting, STARVE_LIMIT=4 -> cycles 1-4 MEM granted; cycle 5 IF granted, mem_stall_req_o=1; cycle 6 MEM granted again.
4. Buffer: IF 0x80000008 granted with pipe_stall_i=1, then 2 more stalled cycles while MEM stores to 0x80400010 -> MEM granted, if_stall_req_o=0, if_inst_o stays equal to the buffered word.
5. Invalidate: buffered 0x80000008, then MEM write to 0x80000008 -> buf_valid=0; next fetch of 0x80000008 goes to RAM.
6. rst asserted mid-conflict, 1 cycle -> all outputs 0, state S_IF. With ARB_PERF_CNT_EN, perf_if_stall_o=0 after reset and counts 3 after 3 stalled cycles.
